// File: rtl/instr_encoder.sv
// instr_encoder: assembles 32-bit instruction words from decoded fields and streams them with sequential
// addresses through a 2-entry output FIFO (optional INSTR_PARITY_EN adds a stored per-word parity output)
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [4:0]        unused,
  input  logic [15:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
`ifdef INSTR_PARITY_EN
  output logic              out_parity,
`endif
  output logic              busy,
  output logic              done,
  output logic              err
);
`ifdef INSTR_PARITY_EN
  localparam int EW = 33;
`else
  localparam int EW = 32;
`endif
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_cnt, r_len;
  logic [EW-1:0]     r_mem [2];
  logic              r_wp, r_rp;
  logic [1:0]        r_occ;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              w_full, w_start, w_acc, w_ill, w_push, w_pop;
  logic [31:0]       w_word;
  logic [EW-1:0]     w_entry, w_head;
  assign w_full   = r_occ == 2'(FIFO_DEPTH);
  assign w_start  = start & (r_state == S_IDLE | r_state == S_DONE);
  assign w_ill    = fmt == 2'b11;
  assign w_acc    = in_valid & in_ready;
  assign w_push   = w_acc & !w_ill;
  assign w_pop    = out_valid & out_ready;
  assign w_word   = fmt == 2'b00 ? {opcode, rs, rt, rd, shamt, 1'b0, unused} : {opcode, rs, rt, imm};
`ifdef INSTR_PARITY_EN
  assign w_entry    = {^w_word, w_word};
  assign out_parity = out_valid & w_head[32];
`else
  assign w_entry  = w_word;
`endif
  assign w_head    = r_mem[r_rp];
  assign in_ready  = (r_state == S_RUN) & !w_full & (r_cnt < r_len);
  assign out_valid = r_occ != 2'd0;
  assign out_instr = out_valid ? w_head[31:0] : 32'd0;
  assign out_addr  = r_addr;
  assign busy      = r_state == S_RUN | r_state == S_DRAIN;
  assign done      = r_state == S_DONE;
  assign err       = r_err;
  // session sequencing: RUN until the programmed count is reached, then drain the FIFO
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_RUN : r_state;
      S_RUN:          w_next = r_cnt == r_len ? S_DRAIN : S_RUN;
      S_DRAIN:        w_next = r_occ == 2'd0 ? S_DONE : S_DRAIN;
      default:        w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  // session bookkeeping: accepted legal count, latched length, sticky illegal flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_len <= prog_len;
      r_err <= 1'b0;
    end else begin
      if (w_push) r_cnt <= r_cnt + 1'b1;
      if (w_acc & w_ill) r_err <= 1'b1;
    end
  // write address of the head word advances on every pop and wraps naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       r_addr <= '0;
    else if (w_start) r_addr <= '0;
    else if (w_pop)   r_addr <= r_addr + 1'b1;
  // two-entry FIFO; storage is cleared on reset so the head reads 0 afterwards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_entry;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder
module tb_instr_encoder;
  localparam int AW = 8;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [1:0]    fmt = '0;
  logic [5:0]    opcode = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0, unused = '0;
  logic [15:0]   imm = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          busy, done, err;
`ifdef INSTR_PARITY_EN
  logic          out_parity;
`endif

  instr_encoder #(.ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .unused(unused), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
`ifdef INSTR_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] w; logic [AW-1:0] a; } exp_t;
  exp_t          sb[$];
  exp_t          e;
  int            checks = 0, errors = 0;
  int            sess_len = 0, sess_cnt = 0;
  logic [AW-1:0] sess_addr = '0;
  bit            exp_err = 0;
  int            or_mode = 0;
  bit            hold = 0;
  logic [31:0]   h_instr;
  logic [AW-1:0] h_addr;

  function automatic logic [31:0] encode(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] a, b, c, d, u, input logic [15:0] im);
    logic [31:0] v;
    v = 32'(op) * 32'h0400_0000 + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000;
    return f == 2'd0 ? v + 32'(c) * 32'd2048 + 32'(d) * 32'd64 + 32'(u) : v + 32'(im);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: samples handshakes at the falling edge, ahead of the rising edge where they take effect
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold) begin
        chk("hold_instr", out_instr, h_instr);
        chk("hold_addr", out_addr, h_addr);
      end
      hold = out_valid & !out_ready;
      h_instr = out_instr;
      h_addr = out_addr;
      if (in_ready) begin
        chk("ready_not_full", sb.size() < 2, 1);
        chk("ready_below_len", sess_cnt < sess_len, 1);
      end
      if (out_valid & out_ready) begin
        if (sb.size() == 0) chk("unexpected_pop", 1, 0);
        else begin
          e = sb.pop_front();
          chk("instr", out_instr, e.w);
          chk("addr", out_addr, e.a);
`ifdef INSTR_PARITY_EN
          chk("parity", out_parity, ^e.w);
`endif
        end
      end
      if (in_valid & in_ready) begin
        if (fmt == 2'b11) exp_err = 1;
        else begin
          sb.push_back({encode(fmt, opcode, rs, rt, rd, shamt, unused, imm), sess_addr});
          sess_addr++;
          sess_cnt++;
        end
      end
    end else hold = 0;
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = or_mode == 0 ? 1'b1 : or_mode == 1 ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a, b, c, d, u,
      input logic [15:0] im);
    int n;
    fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = d; unused = u; imm = im;
    in_valid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 500) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit ill);
    drive(ill ? 2'd3 : 2'($urandom_range(0, 2)), 6'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
  endtask

  task automatic begin_sess(input int len);
    tick();
    sess_len = len; sess_cnt = 0; sess_addr = '0; exp_err = 0;
    prog_len = (AW+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_sess();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_reached", done, 1);
    chk("busy_at_done", busy, 0);
    chk("err_flag", err, exp_err);
    chk("sb_empty", sb.size(), 0);
    chk("no_valid_at_done", out_valid, 0);
    chk("accepted_count", sess_cnt, sess_len);
    tick();
  endtask

  task automatic rand_sess(input int len, input int ill_pct);
    int it = 0;
    begin_sess(len);
    while (sess_cnt < len && it < 10 * len + 50) begin
      send_rand($urandom_range(0, 99) < ill_pct);
      repeat ($urandom_range(0, 2)) tick();
      it++;
    end
    fmt = 2'd0; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ready_after_len", in_ready, 0);
    end
    tick();
    in_valid = 1'b0;
    finish_sess();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_instr"}, out_instr, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
`ifdef INSTR_PARITY_EN
    chk({tag, "_parity"}, out_parity, 0);
`endif
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    #4 rst_n = 1'b1;
    // directed R then I (I-type carries junk in rd/shamt/unused that must be ignored)
    or_mode = 0;
    begin_sess(2);
    drive(2'd0, 6'd0, 5'd3, 5'd8, 5'd16, 5'd0, 5'd17, 16'hBEEF);
    drive(2'd1, 6'h0C, 5'd1, 5'd16, 5'd7, 5'd9, 5'd31, 16'h4032);
    finish_sess();
    // back-pressure: three bundles offered while memory stalls
    or_mode = 1;
    fork
      begin
        begin_sess(3);
        repeat (3) send_rand(0);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_occupancy", sb.size(), 2);
        chk("full_head_addr", out_addr, 0);
        or_mode = 0;
      end
    join
    finish_sess();
    // illegal bundle followed by a branch
    begin_sess(1);
    drive(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF);
    drive(2'd2, 6'd4, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0010);
    finish_sess();
    // zero-length session
    begin_sess(0);
    finish_sess();
    // asynchronous reset while a word is pending
    or_mode = 1;
    begin_sess(4);
    send_rand(0);
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    sb.delete();
    sess_len = 0; sess_cnt = 0;
    #4 rst_n = 1'b1;
    or_mode = 0;
    rand_sess(2, 0);
    // long session crossing the address wrap with random stalls and illegal bundles
    or_mode = 2;
    rand_sess(260, 10);
    for (int i = 0; i < 12; i++) begin
      or_mode = $urandom_range(0, 1) ? 2 : 0;
      rand_sess($urandom_range(0, 6), 25);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
